gpio_port: RTL and testbench

- Parametrised successor to the memory-mapped digital port: WIDTH bidirectional pins with a per-pin direction register.
- Adds atomic set/clear/toggle writes, a synchronised input readback, and per-pin rising/falling edge interrupts with a sticky write-1-to-clear status register.
- Sits on the CPU peripheral bus behind the address decoder and drives the board IO pads.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_sync.sv | 38 +++
 rtl/gpio_port.sv | 90 +++++++++
 tb/tb_gpio_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO port: register map and synchroniser depth limits.
package gpio_pkg;

  localparam int ADDR_WIDTH = 4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_OUT     = 4'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_DIR     = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_SET     = 4'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLR     = 4'd3;
  localparam logic [ADDR_WIDTH-1:0] ADDR_TGL     = 4'd4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_IN      = 4'd5;
  localparam logic [ADDR_WIDTH-1:0] ADDR_RISE_EN = 4'd6;
  localparam logic [ADDR_WIDTH-1:0] ADDR_FALL_EN = 4'd7;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = 4'd8;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic bit sync_stages_ok(input int n);
    return n >= MIN_SYNC_STAGES;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pin synchroniser chain plus one-cycle history, producing per-pin rise/fall strobes.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("gpio_sync: SYNC_STAGES must be at least 2");
  end

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stages[i] <= '0;
      prev <= '0;
    end else begin
      stages[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign in_sync = stages[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev;
  assign fall    = ~in_sync & prev;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: output/direction latches, atomic set/clear/toggle,
// synchronised input readback and sticky edge interrupts.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipSelect,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      dataIn,
  output logic [WIDTH-1:0]      dataOut,
  inout  wire  [WIDTH-1:0]      io,
  output logic                  irq
);

  // Bus: a write commits on the clk edge where chipSelect && writeEnable;
  // reads are combinational while chipSelect is high, with no wait states.
  logic             wr;
  logic [WIDTH-1:0] out_reg, dir_reg, rise_en, fall_en, status;
  logic [WIDTH-1:0] in_sync, rise, fall, events, clr_mask;

  assign wr = chipSelect & writeEnable;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pins   (io),
    .in_sync(in_sync),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg <= '0;
      dir_reg <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr) begin
      case (address)
        ADDR_OUT:     out_reg <= dataIn;
        ADDR_DIR:     dir_reg <= dataIn;
        ADDR_SET:     out_reg <= out_reg | dataIn;
        ADDR_CLR:     out_reg <= out_reg & ~dataIn;
        ADDR_TGL:     out_reg <= out_reg ^ dataIn;
        ADDR_RISE_EN: rise_en <= dataIn;
        ADDR_FALL_EN: fall_en <= dataIn;
        default:      ;
      endcase
    end
  end

  // A fresh event on the same edge as a write-1-to-clear keeps the bit set.
  assign events   = (rise & rise_en) | (fall & fall_en);
  assign clr_mask = (wr && address == ADDR_STATUS) ? dataIn : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) status <= '0;
    else        status <= (status & ~clr_mask) | events;
  end

  assign irq = |status;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io[i] = dir_reg[i] ? out_reg[i] : 1'bz;
  end

  always_comb begin
    dataOut = '0;
    if (chipSelect) begin
      case (address)
        ADDR_OUT:     dataOut = out_reg;
        ADDR_DIR:     dataOut = dir_reg;
        ADDR_IN:      dataOut = in_sync;
        ADDR_RISE_EN: dataOut = rise_en;
        ADDR_FALL_EN: dataOut = fall_en;
        ADDR_STATUS:  dataOut = status;
        default:      dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed register-map scenarios followed by random bus
// traffic, all checked against a behavioural model of the port.
module tb_gpio_port;

  localparam int W    = 32;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         chip_select;
  logic         write_enable;
  logic [3:0]   address;
  logic [W-1:0] data_in;
  wire  [W-1:0] data_out;
  wire  [W-1:0] io;
  wire          irq;

  logic [W-1:0] ext_oe;
  logic [W-1:0] ext_val;
  logic [W-1:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // behavioural model state
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status;
  logic [W-1:0] samples[$];  // pad values seen at the last SYNC+1 edges, oldest first

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign io[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end

  gpio_port #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .chipSelect (chip_select),
    .writeEnable(write_enable),
    .address    (address),
    .dataIn     (data_in),
    .dataOut    (data_out),
    .io         (io),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
    samples.delete();
    for (int i = 0; i <= SYNC; i++) samples.push_back('0);
  endfunction

  // IN shows the pad value sampled SYNC-1 edges ago; prev is IN one edge older.
  function automatic logic [W-1:0] model_in();
    return samples[samples.size() - SYNC];
  endfunction

  function automatic logic [W-1:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_out;
      4'd1:    return m_dir;
      4'd5:    return model_in();
      4'd6:    return m_rise;
      4'd7:    return m_fall;
      4'd8:    return m_status;
      default: return '0;
    endcase
  endfunction

  function automatic void model_edge(input logic wr, input logic [3:0] a, input logic [W-1:0] d);
    logic [W-1:0] pad, cur, old, ev, clr;
    pad = (m_dir & m_out) | (~m_dir & ext_val);
    cur = model_in();
    old = samples[samples.size() - SYNC - 1];
    ev  = (cur & ~old & m_rise) | (~cur & old & m_fall);
    clr = (wr && a == 4'd8) ? d : '0;
    m_status = (m_status & ~clr) | ev;
    if (wr) begin
      case (a)
        4'd0: m_out = d;
        4'd1: m_dir = d;
        4'd2: m_out = m_out | d;
        4'd3: m_out = m_out & ~d;
        4'd4: m_out = m_out ^ d;
        4'd6: m_rise = d;
        4'd7: m_fall = d;
        default: ;
      endcase
    end
    samples.push_back(pad);
    void'(samples.pop_front());
  endfunction

  // One bus cycle: drive at negedge, check the read, let the edge happen,
  // then follow DIR with the external drivers and check irq and pads.
  task automatic cycle(input logic cs, input logic we, input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    chip_select  = cs;
    write_enable = we;
    address      = a;
    data_in      = d;
    exp_q.push_back(cs ? model_read(a) : '0);
    #1;
    rd_data = data_out;
    check("read", data_out, exp_q.pop_front());
    @(posedge clk);
    model_edge(cs & we, a, d);
    #1;
    ext_oe = ~m_dir;
    #1;
    check("irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, |m_status});
    check("io", io, (m_dir & m_out) | (~m_dir & ext_val));
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [W-1:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    cycle(1'b1, 1'b0, a, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, '0);
  endtask

  initial begin
    logic [3:0] ra;
    logic       rcs, rwe;

    // reset with pins held high externally
    rst_n = 1'b0; chip_select = 1'b0; write_enable = 1'b0; address = '0; data_in = '0;
    ext_oe = '1; ext_val = '1;
    model_reset();
    #12;
    chip_select = 1'b1;
    address = 4'd0; #1 check("rst_out", data_out, '0);
    address = 4'd1; #1 check("rst_dir", data_out, '0);
    address = 4'd8; #1 check("rst_status", data_out, '0);
    check("rst_irq", {{(W-1){1'b0}}, irq}, '0);
    chip_select = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // direction and pad drive
    wr_reg(4'd1, 32'hFF00FF00);
    wr_reg(4'd0, 32'hFFFFFFFF);
    ext_val = 32'h005500AA;
    rd_reg(4'd1);
    check("dir_readback", rd_data, 32'hFF00FF00);
    check("pads_mixed", io, 32'hFF55FFAA);

    // atomic set/clear/toggle
    wr_reg(4'd0, 32'h0000F0F0);
    wr_reg(4'd2, 32'h0F000000);
    rd_reg(4'd0); check("out_set", rd_data, 32'h0F00F0F0);
    wr_reg(4'd3, 32'h000000F0);
    rd_reg(4'd0); check("out_clr", rd_data, 32'h0F00F000);
    wr_reg(4'd4, 32'hFFFF0000);
    rd_reg(4'd0); check("out_tgl", rd_data, 32'hF0FFF000);

    // input latency
    wr_reg(4'd1, 32'h0);
    ext_val = 32'h0;
    idle(3);
    ext_val = 32'h12345678;
    rd_reg(4'd5);
    rd_reg(4'd5); check("in_after_k", rd_data, 32'h0);
    rd_reg(4'd5); check("in_after_k1", rd_data, 32'h12345678);

    // edge interrupts
    ext_val = 32'h2;
    wr_reg(4'd6, 32'h1);
    wr_reg(4'd7, 32'h2);
    idle(3);
    wr_reg(4'd8, 32'hFFFFFFFF);
    ext_val = 32'h3;
    rd_reg(4'd8);
    rd_reg(4'd8);
    rd_reg(4'd8); check("status_k1", rd_data, 32'h0);
    rd_reg(4'd8); check("status_rise0", rd_data, 32'h1);
    check("irq_rise0", {{(W-1){1'b0}}, irq}, 32'h1);
    ext_val = 32'h1;
    for (int i = 0; i < 4; i++) rd_reg(4'd8);
    check("status_fall1", rd_data, 32'h3);
    ext_val = 32'h0;
    for (int i = 0; i < 4; i++) rd_reg(4'd8);
    check("status_fall0_masked", rd_data, 32'h3);

    // write-1-to-clear colliding with a new rise on pin0
    ext_val = 32'h1;
    idle(2);
    wr_reg(4'd8, 32'h3);
    rd_reg(4'd8); check("w1c_collide", rd_data, 32'h1);
    check("w1c_irq_held", {{(W-1){1'b0}}, irq}, 32'h1);
    wr_reg(4'd8, 32'h1);
    rd_reg(4'd8); check("w1c_clear", rd_data, 32'h0);
    check("w1c_irq_low", {{(W-1){1'b0}}, irq}, 32'h0);

    // asynchronous reset in the middle of operation
    wr_reg(4'd1, 32'hFFFF0000);
    ext_val = 32'h0;
    idle(3);
    ext_val = 32'h1;
    idle(4);
    check("pre_rst_status", m_status, 32'h1);
    @(negedge clk);
    write_enable = 1'b0;
    chip_select  = 1'b1;
    #1 rst_n = 1'b0;
    address = 4'd8; #1 check("async_status", data_out, '0);
    check("async_irq", {{(W-1){1'b0}}, irq}, '0);
    address = 4'd0; #1 check("async_out", data_out, '0);
    address = 4'd1; #1 check("async_dir", data_out, '0);
    ext_oe = '1; ext_val = '0;
    #1 check("async_pads_released", io, '0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) ext_val = ext_val ^ ($urandom() & $urandom());
      ra  = 4'($urandom_range(0, 15));
      rcs = ($urandom_range(0, 3) != 0);
      rwe = 1'($urandom_range(0, 1));
      cycle(rcs, rwe, ra, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0t expected=finish", $time);
    $fatal(1);
  end

endmodule
